// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: drives the PC register, runs the imem request/ready
// handshake and owns the IF/ID register with a one-entry skid buffer.
module ifetch_ctrl (
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] pc,
   output logic [31:0] npc,
   output logic        pc_wen,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      SKID  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_q;
   logic        id_valid_q;
   logic [31:0] id_inst_q;
   logic [31:0] id_pc_q;
   logic [31:0] id_pc4_q;
   logic [31:0] skid_inst_q;
   logic [31:0] skid_pc_q;
   logic [31:0] skid_pc4_q;
   logic [31:0] drain_addr_q;

   logic        accept;
   logic [31:0] pc4;
   logic        unused_redirect_lsb;

   assign accept              = !id_valid_q || !stall;
   assign pc4                 = pc + 32'd4;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // imem handshake: imem_req stays high with imem_addr frozen until a cycle with
   // imem_ready=1 completes the request; imem_rdata is sampled only in that cycle.
   assign npc       = redirect ? {redirect_pc[31:2], 2'b00} : pc4;
   assign imem_req  = clrn && (state_q != SKID);
   assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc;
   assign pc_wen    = clrn && (redirect || ((state_q == FETCH) && imem_ready));

   assign id_valid  = id_valid_q;
   assign id_inst   = id_inst_q;
   assign id_pc     = id_pc_q;
   assign id_pc4    = id_pc4_q;
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q      <= FETCH;
         id_valid_q   <= 1'b0;
         id_inst_q    <= 32'd0;
         id_pc_q      <= 32'd0;
         id_pc4_q     <= 32'd0;
         skid_inst_q  <= 32'd0;
         skid_pc_q    <= 32'd0;
         skid_pc4_q   <= 32'd0;
         drain_addr_q <= 32'd0;
      end else if (redirect) begin
         // Flush wins over everything; an in-flight request must still be drained.
         id_valid_q  <= 1'b0;
         skid_inst_q <= 32'd0;
         skid_pc_q   <= 32'd0;
         skid_pc4_q  <= 32'd0;
         case (state_q)
            FETCH: begin
               if (!imem_ready) begin
                  state_q      <= DRAIN;
                  drain_addr_q <= pc;
               end
            end
            SKID:    state_q <= FETCH;
            default: if (imem_ready) state_q <= FETCH;
         endcase
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ready && accept) begin
                  id_valid_q <= 1'b1;
                  id_inst_q  <= imem_rdata;
                  id_pc_q    <= pc;
                  id_pc4_q   <= pc4;
               end else if (imem_ready) begin
                  skid_inst_q <= imem_rdata;
                  skid_pc_q   <= pc;
                  skid_pc4_q  <= pc4;
                  state_q     <= SKID;
               end else if (accept) begin
                  id_valid_q <= 1'b0;
               end
            end
            SKID: begin
               if (accept) begin
                  id_valid_q <= 1'b1;
                  id_inst_q  <= skid_inst_q;
                  id_pc_q    <= skid_pc_q;
                  id_pc4_q   <= skid_pc4_q;
                  state_q    <= FETCH;
               end
            end
            default: begin
               if (accept) id_valid_q <= 1'b0;
               if (imem_ready) state_q <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: a PC register model, a directed cycle script and a
// scoreboard that pops each IF/ID entry as decode consumes it.
module tb_ifetch_ctrl;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_SKID  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [31:0] XOR_PAT = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic [31:0] pc;
   logic [31:0] npc;
   logic        pc_wen;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   ifetch_ctrl dut (
      .clk         (clk),
      .clrn        (clrn),
      .pc          (pc),
      .npc         (npc),
      .pc_wen      (pc_wen),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (id_valid),
      .id_inst     (id_inst),
      .id_pc       (id_pc),
      .id_pc4      (id_pc4),
      .dbg_state   (dbg_state)
   );

   // clock / reset / environment
   always #5 clk = ~clk;

   always @(posedge clk or negedge clrn) begin
      if (!clrn) pc <= 32'd0;
      else if (pc_wen) pc <= npc;
   end

   assign imem_rdata = imem_addr ^ XOR_PAT;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rdy, input logic stl, input logic rd, input logic [31:0] rpc);
      imem_ready  = rdy;
      stall       = stl;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
   endtask

   task automatic push(input logic [31:0] addr);
      exp_q.push_back(addr);
   endtask

   // scoreboard: an entry is consumed by decode at the edge where id_valid & !stall
   always @(negedge clk) begin
      logic [31:0] e;
      if (clrn && id_valid && !stall && !redirect) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_entry", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("sb_id_pc", id_pc, e);
            check("sb_id_inst", id_inst, e ^ XOR_PAT);
            check("sb_id_pc4", id_pc4, e + 32'd4);
         end
      end
   end

   initial begin
      imem_ready  = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", imem_req, 1'b0);
      check("rst_wen", pc_wen, 1'b0);
      check("rst_id_valid", id_valid, 1'b0);
      check("rst_id_pc", id_pc, 32'd0);
      check("rst_id_inst", id_inst, 32'd0);
      check("rst_state", dbg_state, ST_FETCH);

      // zero-wait fetch
      clrn = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("zw_addr", imem_addr, 32'(i * 4));
         check("zw_wen", pc_wen, 1'b1);
         if (i > 0) check("zw_id_valid", id_valid, 1'b1);
         push(32'(i * 4));
         cyc();
      end

      // two wait states per request
      for (int f = 0; f < 2; f++) begin
         for (int w = 0; w < 3; w++) begin
            drive(w == 2, 1'b0, 1'b0, 32'd0);
            check("ws_addr", imem_addr, 32'h10 + 32'(f * 4));
            check("ws_req", imem_req, 1'b1);
            check("ws_wen", pc_wen, w == 2);
            if (w == 2) push(32'h10 + 32'(f * 4));
            cyc();
         end
      end

      // stall while a fetch of 0x18 returns
      drive(1'b1, 1'b1, 1'b0, 32'd0);
      check("sk_wen", pc_wen, 1'b1);
      push(32'h18);
      cyc();
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b1, 1'b0, 32'd0);
         check("sk_state", dbg_state, ST_SKID);
         check("sk_req", imem_req, 1'b0);
         check("sk_wen", pc_wen, 1'b0);
         check("sk_hold_pc", id_pc, 32'h14);
         cyc();
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check("sk_rel_req", imem_req, 1'b0);
      cyc();
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      check("sk_out_pc", id_pc, 32'h18);
      check("sk_out_state", dbg_state, ST_FETCH);
      check("sk_next_addr", imem_addr, 32'h1C);
      push(32'h1C);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      cyc();
      check("sk_sb_empty", 32'(exp_q.size()), 32'd0);

      // redirect while the request at 0x20 is outstanding
      drive(1'b0, 1'b0, 1'b1, 32'h103);
      check("rd_npc", npc, 32'h100);
      check("rd_wen", pc_wen, 1'b1);
      check("rd_addr", imem_addr, 32'h20);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check("dr_state", dbg_state, ST_DRAIN);
      check("dr_req", imem_req, 1'b1);
      check("dr_addr", imem_addr, 32'h20);
      check("dr_wen", pc_wen, 1'b0);
      check("dr_id_valid", id_valid, 1'b0);
      check("dr_pc", pc, 32'h100);
      cyc();
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      check("dr_addr_ready", imem_addr, 32'h20);
      check("dr_wen_ready", pc_wen, 1'b0);
      cyc();
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      check("dr_back_state", dbg_state, ST_FETCH);
      check("dr_new_addr", imem_addr, 32'h100);
      check("dr_no_valid", id_valid, 1'b0);
      push(32'h100);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      cyc();

      // redirect + ready + stall together, then PC wrap
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      cyc();
      drive(1'b1, 1'b1, 1'b1, 32'hFFFFFFFC);
      check("sim_id_valid_pre", id_valid, 1'b1);
      check("sim_npc", npc, 32'hFFFFFFFC);
      check("sim_wen", pc_wen, 1'b1);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check("sim_flush", id_valid, 1'b0);
      check("sim_state", dbg_state, ST_FETCH);
      check("sim_addr", imem_addr, 32'hFFFFFFFC);
      check("wrap_npc", npc, 32'd0);
      cyc();
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      check("wrap_wen", pc_wen, 1'b1);
      push(32'hFFFFFFFC);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      check("wrap_pc", pc, 32'd0);
      cyc();

      // reset pulse while in SKID
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      cyc();
      drive(1'b1, 1'b1, 1'b0, 32'd0);
      cyc();
      drive(1'b1, 1'b1, 1'b0, 32'd0);
      check("rs_state_pre", dbg_state, ST_SKID);
      check("rs_id_valid_pre", id_valid, 1'b1);
      clrn = 1'b0;
      #1;
      check("rs_id_valid", id_valid, 1'b0);
      check("rs_req", imem_req, 1'b0);
      check("rs_wen", pc_wen, 1'b0);
      check("rs_state", dbg_state, ST_FETCH);
      check("rs_id_pc", id_pc, 32'd0);
      check("rs_pc", pc, 32'd0);
      cyc();
      clrn = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      check("rs_resume_req", imem_req, 1'b1);
      check("rs_resume_addr", imem_addr, 32'd0);
      push(32'd0);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      cyc();
      cyc();
      check("final_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller feeding the 32-bit PC register (`dffe32`) of the pipelined CPU. It produces the PC register's next value and write enable, runs the request/ready handshake with instruction memory, and owns the IF/ID pipeline register, including a one-entry skid buffer for decode stalls. It handles redirects from branches and jumps, including redirects that arrive while a memory request is still outstanding.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  clock; all state updates on its rising edge.
- clrn  in  1  asynchronous, active-low reset.
- pc  in  32  current PC, from the `dffe32` q output.
- npc  out  32  next PC, to the `dffe32` d input.
- pc_wen  out  1  PC write enable, to the `dffe32` en input.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; held stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- stall  in  1  decode cannot accept a new IF/ID entry.
- redirect  in  1  branch or jump taken.
- redirect_pc  in  32  redirect target.
- id_valid  out  1  IF/ID holds a real instruction.
- id_inst  out  32  IF/ID instruction.
- id_pc  out  32  IF/ID PC.
- id_pc4  out  32  IF/ID PC+4.

## Operation
- **Definitions:** accept = !id_valid | !stall. pc4 = pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- **npc:** redirect ? {redirect_pc[31:2],2'b00} : pc4. The low bits of a redirect target are forced to 00.
- **States:** FETCH, SKID, DRAIN.
- **FETCH:** imem_req=1, imem_addr=pc.
  - ready & !redirect & accept: load IF/ID with {rdata, pc, pc4}, id_valid=1, pc_wen=1.
  - ready & !redirect & !accept: skid<={rdata, pc, pc4}, pc_wen=1, go to SKID.
  - redirect & ready: discard rdata, pc_wen=1 (npc = target), stay in FETCH.
  - redirect & !ready: drain_addr<=pc, pc_wen=1, go to DRAIN.
- **SKID:** imem_req=0.
  - accept & !redirect: IF/ID<=skid, id_valid=1, go to FETCH.
- **DRAIN:** imem_req=1, imem_addr=drain_addr.
  - ready: discard rdata, go to FETCH. pc_wen=0 unless redirect is also asserted.
- **Redirect (any state, top priority):**
  - id_valid<=0 (flush), skid cleared, pc_wen=1.
  - SKID → FETCH.
  - In DRAIN, the state is kept until ready; only pc changes.
- **IF/ID update when not redirecting:**
  - If accept and no new instruction is available: id_valid<=0 (bubble).
  - If stall & id_valid: all IF/ID fields hold.
  - id_inst, id_pc and id_pc4 keep their last values when id_valid falls.
- pc_wen=0 in every case not listed above.
- The block never issues a new request while an instruction is held in the skid buffer, so at most two fetched instructions are held at once.

## Timing
- **Reset:** state=FETCH, id_valid=0, id_inst/id_pc/id_pc4=0, skid and drain_addr cleared.
  - While clrn=0: imem_req=0 and pc_wen=0.
  - The first request goes out in the first cycle after release, at pc (0 after reset).
- **Zero-wait memory:** one fetch per cycle. The instruction fetched at cycle n appears on id_* at cycle n+1.
- npc, pc_wen, imem_req and imem_addr are combinational from state, inputs and pc. All other outputs are registered.
- **Redirect:** takes effect on the PC at the next edge. The first fetch from the target is issued in that next cycle from FETCH or SKID; from DRAIN it starts once the outstanding request completes.
- **Reset mid-operation** (any state): immediate return to the reset values. Skid and drain contents are lost.

## Test plan
- **Zero-wait fetch:** reset, imem_ready=1, rdata=addr^0xA5A5A5A5 → id_pc sequence 0,4,8,C; id_valid=1 from the second post-reset cycle; pc_wen=1 every cycle.
- **Wait states:** ready asserted 2 cycles after each request → imem_addr stable throughout, pc_wen pulses only in ready cycles, no duplicate id_pc.
- **Stall and skid:** id_valid=1, stall=1 for 3 cycles while a fetch of 0x8 returns → SKID, imem_req=0. Stall released → id_pc=0x8 next cycle, then a fetch at 0xC; nothing lost or duplicated.
- **Redirect during outstanding request:** redirect=1, redirect_pc=0x103, ready=0 at pc=0x10 → DRAIN with imem_addr=0x10 held; the returned word is discarded; the next request goes to 0x100; id_valid=0 meanwhile.
- **Simultaneous events:** redirect + ready + stall in the same cycle → id_valid=0, npc=target, rdata dropped, state FETCH. Also check wrap: pc=0xFFFFFFFC → npc=0.
- **Reset mid-SKID:** clrn pulsed low while in SKID → id_valid=0 and imem_req=0 immediately; fetch resumes at 0 after release.
